// File: rtl/sprite_compositor_if.sv
// Bundle of the vga pixel stream, sprite update port, commit control and
// composited outputs that connect a driver to sprite_compositor.
interface sprite_compositor_if #(
    parameter int NUM_SPRITES = 4,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int RGB_W       = 12,
    parameter int SIZE_W      = 7,
    parameter int IDX_W       = $clog2(NUM_SPRITES)
);
    logic [X_W-1:0]         pixel_x_i;
    logic [Y_W-1:0]         pixel_y_i;
    logic                   visible_i;
    logic                   hsync_i;
    logic                   vsync_i;
    logic                   upd_valid_i;
    logic                   upd_ready_o;
    logic [IDX_W-1:0]       upd_idx_i;
    logic                   upd_en_i;
    logic [X_W-1:0]         upd_x_i;
    logic [Y_W-1:0]         upd_y_i;
    logic [SIZE_W-1:0]      upd_w_i;
    logic [SIZE_W-1:0]      upd_h_i;
    logic [RGB_W-1:0]       upd_rgb_i;
    logic                   commit_i;
    logic                   commit_pending_o;
    logic                   hsync_o;
    logic                   vsync_o;
    logic [RGB_W-1:0]       rgb_o;
    logic                   new_frame_o;
    logic [NUM_SPRITES-1:0] collision_mask_o;

    modport master (
        output pixel_x_i, pixel_y_i, visible_i, hsync_i, vsync_i,
        output upd_valid_i, upd_idx_i, upd_en_i, upd_x_i, upd_y_i,
        output upd_w_i, upd_h_i, upd_rgb_i, commit_i,
        input  upd_ready_o, commit_pending_o, hsync_o, vsync_o, rgb_o,
        input  new_frame_o, collision_mask_o
    );

    modport slave (
        input  pixel_x_i, pixel_y_i, visible_i, hsync_i, vsync_i,
        input  upd_valid_i, upd_idx_i, upd_en_i, upd_x_i, upd_y_i,
        input  upd_w_i, upd_h_i, upd_rgb_i, commit_i,
        output upd_ready_o, commit_pending_o, hsync_o, vsync_o, rgb_o,
        output new_frame_o, collision_mask_o
    );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: shadow/active sprite banks swapped at frame
// boundaries, priority colour select, and a per-frame collision mask.
module sprite_compositor #(
    parameter int NUM_SPRITES            = 4,
    parameter int X_W                    = 10,
    parameter int Y_W                    = 10,
    parameter int RGB_W                  = 12,
    parameter int SIZE_W                 = 7,
    parameter logic [RGB_W-1:0] BG_RGB   = '0,
    parameter int IDX_W                  = $clog2(NUM_SPRITES)
) (
    input logic                clk_i,
    input logic                rst_i,
    sprite_compositor_if.slave bus
);
    localparam int XE  = X_W + 1;
    localparam int YE  = Y_W + 1;
    localparam int IW1 = IDX_W + 1;
    localparam logic [IDX_W:0]         NUM_L = IW1'(NUM_SPRITES);
    localparam logic [NUM_SPRITES-1:0] ONE_L = NUM_SPRITES'(1);

    typedef struct packed {
        logic              en;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [SIZE_W-1:0] w;
        logic [SIZE_W-1:0] h;
        logic [RGB_W-1:0]  rgb;
    } slot_t;

    slot_t r_shadow [NUM_SPRITES];
    slot_t r_active [NUM_SPRITES];

    logic [X_W-1:0]         r_x;
    logic [Y_W-1:0]         r_y;
    logic                   r_vis;
    logic                   r_hs;
    logic                   r_vs;
    logic                   r_vsPrev;
    logic                   r_newFrame;
    logic                   r_hso;
    logic                   r_vso;
    logic [RGB_W-1:0]       r_rgb;
    logic                   r_pending;
    logic [NUM_SPRITES-1:0] r_acc;
    logic [NUM_SPRITES-1:0] r_mask;

    logic [NUM_SPRITES-1:0] w_hit;
    logic [NUM_SPRITES-1:0] w_coll;
    logic [RGB_W-1:0]       w_rgbSel;
    logic                   w_swap;
    logic                   w_ready;
    logic                   w_idxOk;

    assign w_swap  = r_newFrame && (r_pending || bus.commit_i);
    assign w_ready = !w_swap;
    assign w_idxOk = {1'b0, bus.upd_idx_i} < NUM_L;

    // Edges are widened by one bit so a sprite past the raster edge clips instead of wrapping.
    always_comb begin
        w_hit    = '0;
        w_coll   = '0;
        w_rgbSel = BG_RGB;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_hit[i] = r_active[i].en
                && (XE'(r_x) >= XE'(r_active[i].x))
                && (XE'(r_x) <  XE'(r_active[i].x) + XE'(r_active[i].w))
                && (YE'(r_y) >= YE'(r_active[i].y))
                && (YE'(r_y) <  YE'(r_active[i].y) + YE'(r_active[i].h));
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_rgbSel = r_active[i].rgb;
            end
        end
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_coll[i] = w_hit[i] && ((w_hit & ~(ONE_L << i)) != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x        <= '0;
            r_y        <= '0;
            r_vis      <= 1'b0;
            r_hs       <= 1'b1;
            r_vs       <= 1'b1;
            r_vsPrev   <= 1'b1;
            r_newFrame <= 1'b0;
            r_hso      <= 1'b1;
            r_vso      <= 1'b1;
            r_rgb      <= '0;
            r_pending  <= 1'b0;
            r_acc      <= '0;
            r_mask     <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_x        <= bus.pixel_x_i;
            r_y        <= bus.pixel_y_i;
            r_vis      <= bus.visible_i;
            r_hs       <= bus.hsync_i;
            r_vs       <= bus.vsync_i;
            r_vsPrev   <= r_vs;
            r_newFrame <= r_vsPrev && !r_vs;
            r_hso      <= r_hs;
            r_vso      <= r_vs;
            r_rgb      <= r_vis ? w_rgbSel : '0;

            if (r_newFrame) begin
                r_mask <= r_acc;
                r_acc  <= '0;
            end else if (r_vis) begin
                r_acc <= r_acc | w_coll;
            end

            // The update port is stalled during the swap, so the copy never races a write.
            if (w_swap) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (bus.commit_i) begin
                r_pending <= 1'b1;
            end

            if (bus.upd_valid_i && w_ready && w_idxOk) begin
                r_shadow[bus.upd_idx_i] <= '{en:  bus.upd_en_i,
                                             x:   bus.upd_x_i,
                                             y:   bus.upd_y_i,
                                             w:   bus.upd_w_i,
                                             h:   bus.upd_h_i,
                                             rgb: bus.upd_rgb_i};
            end
        end
    end

    assign bus.upd_ready_o      = w_ready;
    assign bus.commit_pending_o = r_pending;
    assign bus.hsync_o          = r_hso;
    assign bus.vsync_o          = r_vso;
    assign bus.rgb_o            = r_rgb;
    assign bus.new_frame_o      = r_newFrame;
    assign bus.collision_mask_o = r_mask;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a pixel-stream scoreboard backed by a
// rectangle model of the sprite banks, plus commit/collision/reset checks.
module tb_sprite_compositor;
    localparam int NS = 4;
    localparam logic [11:0] BG = 12'h123;

    typedef struct {
        int en;
        int x;
        int y;
        int w;
        int h;
        int rgb;
    } spr_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        nf;
    } exp_t;

    logic clk_i;
    logic rst_i;

    sprite_compositor_if #(.NUM_SPRITES(NS), .X_W(10), .Y_W(10), .RGB_W(12), .SIZE_W(7)) bus ();

    sprite_compositor #(
        .NUM_SPRITES(NS), .X_W(10), .Y_W(10), .RGB_W(12), .SIZE_W(7), .BG_RGB(BG)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    spr_t     mAct [NS];
    spr_t     mSh  [NS];
    bit       mPending;
    bit       mPrevVs;
    bit [3:0] mAcc;
    bit [3:0] mMask;
    exp_t     q [$];
    int       checks;
    int       errors;

    // Reference rectangle test in plain integers, where no wrap is possible.
    function automatic bit hitM(int i, int x, int y);
        return mAct[i].en != 0 && x >= mAct[i].x && x < mAct[i].x + mAct[i].w
            && y >= mAct[i].y && y < mAct[i].y + mAct[i].h;
    endfunction

    function automatic int expColor(int x, int y);
        for (int i = 0; i < NS; i++) begin
            if (hitM(i, x, y)) return mAct[i].rgb;
        end
        return int'(BG);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One pixel per clock; the entry pushed two steps ago is due at the outputs now.
    task automatic applyStimulus(input int x, input int y, input bit vis, input bit hs, input bit vs);
        exp_t e;
        int   cnt;
        bit [3:0] h;
        @(negedge clk_i);
        bus.upd_valid_i = 1'b0;
        bus.commit_i    = 1'b0;
        if (q.size() == 2) begin
            e = q.pop_front();
            checkOutput("rgb",       32'(bus.rgb_o),       32'(e.rgb));
            checkOutput("hsync",     32'(bus.hsync_o),     32'(e.hs));
            checkOutput("vsync",     32'(bus.vsync_o),     32'(e.vs));
            checkOutput("new_frame", 32'(bus.new_frame_o), 32'(e.nf));
        end
        bus.pixel_x_i = 10'(x);
        bus.pixel_y_i = 10'(y);
        bus.visible_i = vis;
        bus.hsync_i   = hs;
        bus.vsync_i   = vs;
        e.rgb = vis ? 12'(expColor(x, y)) : 12'h000;
        e.hs  = hs;
        e.vs  = vs;
        e.nf  = mPrevVs && !vs;
        mPrevVs = vs;
        if (vis) begin
            cnt = 0;
            h   = '0;
            for (int i = 0; i < NS; i++) begin
                if (hitM(i, x, y)) begin
                    h[i] = 1'b1;
                    cnt++;
                end
            end
            if (cnt >= 2) mAcc |= h;
        end
        q.push_back(e);
    endtask

    task automatic scanRow(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) applyStimulus(x, y, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, y, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic vsyncPulse(input bit commitAtNf);
        repeat (3) applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
        if (commitAtNf) bus.commit_i = 1'b1;
        #1;
        checkOutput("nf_now", 32'(bus.new_frame_o), 32'd1);
        checkOutput("ready_swap", 32'(bus.upd_ready_o), 32'(!(mPending || commitAtNf)));
        if (mPending || commitAtNf) begin
            mAct     = mSh;
            mPending = 1'b0;
        end
        mMask = mAcc;
        mAcc  = '0;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
        checkOutput("pending_after_nf", 32'(bus.commit_pending_o), 32'(mPending));
        checkOutput("collision_mask",   32'(bus.collision_mask_o), 32'(mMask));
    endtask

    task automatic writeSlot(input int idx, input int en, input int x, input int y,
                             input int w, input int h, input int rgb);
        bus.upd_idx_i   = 2'(idx);
        bus.upd_en_i    = en[0];
        bus.upd_x_i     = 10'(x);
        bus.upd_y_i     = 10'(y);
        bus.upd_w_i     = 7'(w);
        bus.upd_h_i     = 7'(h);
        bus.upd_rgb_i   = 12'(rgb);
        bus.upd_valid_i = 1'b1;
        #1;
        checkOutput("ready_idle", 32'(bus.upd_ready_o), 32'd1);
        mSh[idx] = '{en, x, y, w, h, rgb};
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic commitReq();
        bus.commit_i = 1'b1;
        mPending     = 1'b1;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
        checkOutput("pending_set", 32'(bus.commit_pending_o), 32'd1);
    endtask

    task automatic assertReset();
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.upd_valid_i = 1'b0;
        bus.commit_i    = 1'b0;
        bus.visible_i   = 1'b0;
        bus.hsync_i     = 1'b1;
        bus.vsync_i     = 1'b1;
        q.delete();
        repeat (2) @(negedge clk_i);
        checkOutput("rst_rgb",     32'(bus.rgb_o),            32'd0);
        checkOutput("rst_hsync",   32'(bus.hsync_o),          32'd1);
        checkOutput("rst_vsync",   32'(bus.vsync_o),          32'd1);
        checkOutput("rst_nf",      32'(bus.new_frame_o),      32'd0);
        checkOutput("rst_pending", 32'(bus.commit_pending_o), 32'd0);
        checkOutput("rst_mask",    32'(bus.collision_mask_o), 32'd0);
        checkOutput("rst_ready",   32'(bus.upd_ready_o),      32'd1);
        for (int i = 0; i < NS; i++) begin
            mAct[i] = '{0, 0, 0, 0, 0, 0};
            mSh[i]  = '{0, 0, 0, 0, 0, 0};
        end
        mPending = 1'b0;
        mPrevVs  = 1'b1;
        mAcc     = '0;
        mMask    = '0;
        rst_i    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_i  = 1'b1;
        bus.pixel_x_i = '0;
        bus.pixel_y_i = '0;
        bus.visible_i = 1'b0;
        bus.hsync_i   = 1'b1;
        bus.vsync_i   = 1'b1;
        bus.upd_valid_i = 1'b0;
        bus.upd_idx_i = '0;
        bus.upd_en_i  = 1'b0;
        bus.upd_x_i   = '0;
        bus.upd_y_i   = '0;
        bus.upd_w_i   = '0;
        bus.upd_h_i   = '0;
        bus.upd_rgb_i = '0;
        bus.commit_i  = 1'b0;

        assertReset();

        $display("[TB] empty frame");
        vsyncPulse(1'b0);
        scanRow(20, 8, 15);
        scanRow(21, 8, 15);
        vsyncPulse(1'b0);

        $display("[TB] slot 1 commit at next frame");
        writeSlot(1, 1, 10, 20, 4, 3, 12'h0F0);
        commitReq();
        for (int y = 19; y <= 23; y++) scanRow(y, 9, 14);
        vsyncPulse(1'b0);
        for (int y = 19; y <= 23; y++) scanRow(y, 9, 14);

        $display("[TB] slot 0 overlap and collision");
        writeSlot(0, 1, 10, 20, 4, 4, 12'hF00);
        commitReq();
        vsyncPulse(1'b0);
        for (int y = 19; y <= 24; y++) scanRow(y, 9, 14);
        vsyncPulse(1'b0);
        checkOutput("mask_0011", 32'(bus.collision_mask_o), 32'h3);

        $display("[TB] commit coincident with frame pulse");
        writeSlot(2, 1, 30, 30, 2, 2, 12'h00F);
        scanRow(30, 29, 32);
        vsyncPulse(1'b1);
        scanRow(30, 29, 32);
        scanRow(31, 29, 32);

        $display("[TB] right-edge clipping");
        writeSlot(3, 1, 1022, 100, 8, 2, 12'hFFF);
        commitReq();
        vsyncPulse(1'b0);
        scanRow(100, 1018, 1023);
        scanRow(100, 0, 3);
        scanRow(101, 1020, 1023);
        scanRow(102, 1020, 1023);

        $display("[TB] reset with pending commit");
        writeSlot(2, 1, 50, 50, 4, 4, 12'hABC);
        commitReq();
        assertReset();
        vsyncPulse(1'b0);
        scanRow(20, 9, 14);
        scanRow(50, 49, 54);
        vsyncPulse(1'b1);
        scanRow(50, 49, 54);
        scanRow(100, 1020, 1023);
        vsyncPulse(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
